// File: rtl/sipo_deserializer_pkg.sv
// Shared serial definitions: default word width, bit-counter sizing and the
// bit-order encoding common to the PISO/SIPO stages.
package sipo_deserializer_pkg;

   localparam int unsigned DEFAULT_WIDTH = 4;

   typedef enum logic {
      LSB_ORDER = 1'b0,
      MSB_ORDER = 1'b1
   } bit_order_e;

   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/sipo_deserializer_shift_core.sv
// Shift register and bit counter; flags the cycle that collects the last bit
// and presents the completed word combinationally for the output slot.
module sipo_shift_core
   import sipo_deserializer_pkg::*;
#(
   parameter int unsigned WIDTH     = DEFAULT_WIDTH,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         sin,
   input  logic                         sin_valid,
   input  logic                         align,
   output logic [WIDTH-1:0]             word,
   output logic                         complete,
   output logic [cnt_width(WIDTH)-1:0]  bit_cnt
);

   localparam int unsigned CW    = cnt_width(WIDTH);
   localparam bit_order_e  ORDER = MSB_FIRST ? MSB_ORDER : LSB_ORDER;

   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] base;

   // align drops the partial word, so a coincident bit shifts into a clean register
   always_comb begin
      base = align ? '0 : sr;
      if (ORDER == MSB_ORDER) word = {base[WIDTH-2:0], sin};
      else                    word = {sin, base[WIDTH-1:1]};
      complete = sin_valid && !align && (bit_cnt == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sr      <= '0;
         bit_cnt <= '0;
      end else if (sin_valid) begin
         sr <= word;
         if (complete)   bit_cnt <= '0;
         else if (align) bit_cnt <= CW'(1);
         else            bit_cnt <= bit_cnt + CW'(1);
      end else if (align) begin
         sr      <= '0;
         bit_cnt <= '0;
      end
   end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel deserializer: shift core plus a one-word output slot with
// valid/ready handshake and a sticky overrun flag for dropped words.
module sipo_deserializer
   import sipo_deserializer_pkg::*;
#(
   parameter int unsigned WIDTH     = DEFAULT_WIDTH,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         sin,
   input  logic                         sin_valid,
   input  logic                         align,
   output logic [WIDTH-1:0]             dout,
   output logic                         dout_valid,
   input  logic                         dout_ready,
   output logic                         overrun,
   input  logic                         overrun_clr,
   output logic [cnt_width(WIDTH)-1:0]  bit_cnt
);

   logic [WIDTH-1:0] word;
   logic             complete;
   logic             transfer;
   logic             load;
   logic             drop;

   sipo_shift_core #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_core (
      .clk       (clk),
      .reset     (reset),
      .sin       (sin),
      .sin_valid (sin_valid),
      .align     (align),
      .word      (word),
      .complete  (complete),
      .bit_cnt   (bit_cnt)
   );

   always_comb begin
      transfer = dout_valid && dout_ready;
      load     = complete && (!dout_valid || dout_ready);
      drop     = complete && dout_valid && !dout_ready;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dout       <= '0;
         dout_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (load) begin
            dout       <= word;
            dout_valid <= 1'b1;
         end else if (transfer) begin
            dout_valid <= 1'b0;
         end
         // a drop in the same cycle as a clear keeps the flag set
         if (drop)             overrun <= 1'b1;
         else if (overrun_clr) overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench: MSB-first and LSB-first instances share one stimulus stream.
module tb_sipo_deserializer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       sin = 1'b0;
   logic       sin_valid = 1'b0;
   logic       align = 1'b0;
   logic       dout_ready = 1'b0;
   logic       overrun_clr = 1'b0;

   logic [3:0] dout_m, dout_l;
   logic       dv_m, dv_l, ov_m, ov_l;
   logic [2:0] cnt_m, cnt_l;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .align(align),
      .dout(dout_m), .dout_valid(dv_m), .dout_ready(dout_ready),
      .overrun(ov_m), .overrun_clr(overrun_clr), .bit_cnt(cnt_m)
   );

   sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .align(align),
      .dout(dout_l), .dout_valid(dv_l), .dout_ready(dout_ready),
      .overrun(ov_l), .overrun_clr(overrun_clr), .bit_cnt(cnt_l)
   );

   task automatic cyc(input logic s, input logic v, input logic al,
                      input logic rdy, input logic clr, input logic rst);
      sin = s; sin_valid = v; align = al;
      dout_ready = rdy; overrun_clr = clr; reset = rst;
      @(posedge clk);
      #1;
      sin = 1'b0; sin_valid = 1'b0; align = 1'b0; overrun_clr = 1'b0; reset = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      // reset
      cyc(0, 0, 0, 0, 0, 1);
      chk("rst_dout", dout_m, 4'b0000);
      chk("rst_dv", dv_m, 0);
      chk("rst_ov", ov_m, 0);
      chk("rst_cnt", cnt_m, 0);

      // back-to-back 1,0,1,1 with ready high
      cyc(1, 1, 0, 1, 0, 0);
      chk("b2b_cnt1", cnt_m, 1);
      cyc(0, 1, 0, 1, 0, 0);
      cyc(1, 1, 0, 1, 0, 0);
      chk("b2b_cnt3", cnt_m, 3);
      chk("b2b_dv_early", dv_m, 0);
      cyc(1, 1, 0, 1, 0, 0);
      chk("b2b_dout_m", dout_m, 4'b1011);
      chk("b2b_dv", dv_m, 1);
      chk("b2b_cnt0", cnt_m, 0);
      chk("b2b_dout_l", dout_l, 4'b1101);
      cyc(0, 0, 0, 1, 0, 0);
      chk("b2b_drain", dv_m, 0);

      // same bits with gaps
      cyc(1, 1, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);
      chk("gap_cnt_hold1", cnt_m, 1);
      cyc(0, 1, 0, 1, 0, 0);
      cyc(1, 0, 0, 1, 0, 0);
      chk("gap_cnt_hold2", cnt_m, 2);
      cyc(1, 1, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);
      chk("gap_cnt_hold3", cnt_m, 3);
      chk("gap_dv_early", dv_m, 0);
      cyc(1, 1, 0, 1, 0, 0);
      chk("gap_dout", dout_m, 4'b1011);
      chk("gap_dv", dv_m, 1);
      cyc(0, 0, 0, 1, 0, 0);
      chk("gap_drain", dv_m, 0);

      // overrun: 1011 pending, 0110 dropped
      cyc(1, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      chk("ovr_first", dout_m, 4'b1011);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      chk("ovr_hold_mid", dout_m, 4'b1011);
      chk("ovr_not_yet", ov_m, 0);
      cyc(0, 1, 0, 0, 0, 0);
      chk("ovr_dout_held", dout_m, 4'b1011);
      chk("ovr_set", ov_m, 1);
      chk("ovr_dv_held", dv_m, 1);
      chk("ovr_cnt0", cnt_m, 0);
      cyc(0, 0, 0, 1, 0, 0);
      chk("ovr_drain_dv", dv_m, 0);
      chk("ovr_sticky", ov_m, 1);
      cyc(0, 0, 0, 0, 1, 0);
      chk("ovr_clr", ov_m, 0);

      // transfer coincides with completion
      cyc(1, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 1, 0, 0);
      chk("xfer_dout_m", dout_m, 4'b0110);
      chk("xfer_dv", dv_m, 1);
      chk("xfer_ov", ov_m, 0);
      chk("xfer_dout_l", dout_l, 4'b0110);

      // overrun set wins over a same-cycle clear
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 1, 0);
      chk("ovr_set_prio", ov_m, 1);
      chk("ovr_set_prio_dout", dout_m, 4'b0110);
      cyc(0, 0, 0, 1, 1, 0);
      chk("ovr_prio_clr", ov_m, 0);
      chk("ovr_prio_drain", dv_m, 0);

      // align with a valid 0 mid-word, then 1,1,1
      cyc(1, 1, 0, 1, 0, 0);
      cyc(1, 1, 0, 1, 0, 0);
      cyc(0, 1, 1, 1, 0, 0);
      chk("aln_cnt1", cnt_m, 1);
      cyc(1, 1, 0, 1, 0, 0);
      cyc(1, 1, 0, 1, 0, 0);
      cyc(1, 1, 0, 1, 0, 0);
      chk("aln_dout_m", dout_m, 4'b0111);
      chk("aln_dout_l", dout_l, 4'b1110);
      cyc(0, 0, 0, 1, 0, 0);

      // align with a valid 1, then 0,0,0
      cyc(1, 1, 0, 1, 0, 0);
      cyc(1, 1, 0, 1, 0, 0);
      cyc(1, 1, 1, 1, 0, 0);
      cyc(0, 1, 0, 1, 0, 0);
      cyc(0, 1, 0, 1, 0, 0);
      cyc(0, 1, 0, 1, 0, 0);
      chk("aln2_dout_m", dout_m, 4'b1000);
      chk("aln2_dout_l", dout_l, 4'b0001);
      cyc(0, 0, 0, 1, 0, 0);

      // align on the would-be completing bit suppresses completion
      cyc(1, 1, 0, 1, 0, 0);
      cyc(1, 1, 0, 1, 0, 0);
      cyc(1, 1, 0, 1, 0, 0);
      cyc(0, 1, 1, 1, 0, 0);
      chk("aln_cmp_dv", dv_m, 0);
      chk("aln_cmp_cnt", cnt_m, 1);
      cyc(0, 0, 1, 1, 0, 0);
      chk("aln_idle_cnt", cnt_m, 0);

      // reset mid-word with a word pending
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      chk("pre_rst_dv", dv_m, 1);
      cyc(1, 1, 1, 1, 1, 1);
      chk("mid_rst_dout", dout_m, 4'b0000);
      chk("mid_rst_dv", dv_m, 0);
      chk("mid_rst_ov", ov_m, 0);
      chk("mid_rst_cnt", cnt_m, 0);
      cyc(0, 1, 0, 1, 0, 0);
      cyc(1, 1, 0, 1, 0, 0);
      cyc(0, 1, 0, 1, 0, 0);
      cyc(1, 1, 0, 1, 0, 0);
      chk("post_rst_dout_m", dout_m, 4'b0101);
      chk("post_rst_dout_l", dout_l, 4'b1010);
      chk("post_rst_dv", dv_l, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sipo_deserializer.md
SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 Parameter WIDTH, default 4: word width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 means the first received bit lands in dout[WIDTH-1]; 0 means it lands in dout[0].
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port sin, input, 1 bit: serial data bit.
REQ-006 Port sin_valid, input, 1 bit: sin carries a valid bit this cycle.
REQ-007 Port align, input, 1 bit: frame-alignment pulse; restarts word assembly.
REQ-008 Port dout, output, WIDTH bits: assembled parallel word.
REQ-009 Port dout_valid, output, 1 bit: dout holds an unconsumed word.
REQ-010 Port dout_ready, input, 1 bit: the consumer accepts dout this cycle.
REQ-011 Port overrun, output, 1 bit: sticky flag; a completed word was dropped.
REQ-012 Port overrun_clr, input, 1 bit: clears overrun.
REQ-013 Port bit_cnt, output, clog2(WIDTH+1) bits: number of bits collected so far in the current word.

Function
REQ-014 Each cycle with sin_valid=1 shall shift sin into an internal shift register in the MSB_FIRST order and increment bit_cnt.
REQ-015 A cycle with sin_valid=0 shall leave the shift register and bit_cnt unchanged, so gaps between bits are allowed.
REQ-016 The cycle that collects bit WIDTH completes the word; on the next edge bit_cnt shall be 0. Latency from the last bit to dout_valid=1 is 1 cycle.
REQ-017 On completion with the output slot free (dout_valid=0), dout shall load the word and dout_valid shall be set.
REQ-018 A transfer occurs when dout_valid=1 and dout_ready=1; after the edge dout_valid shall be 0 unless a new word loads on that same edge.
REQ-019 If a completion and a transfer happen in the same cycle, the new word shall load, dout_valid shall stay 1, and overrun shall not be set.
REQ-020 If a completion happens while dout_valid=1 and dout_ready=0, the new word shall be discarded, dout shall be held, and overrun shall be set.
REQ-021 While dout_valid=1 and no transfer occurs, dout shall stay stable.
REQ-022 Bit collection shall continue regardless of output backpressure.
REQ-023 align=1 shall discard the partial word. If sin_valid=1 in the same cycle, that bit becomes bit 1 of a new word (bit_cnt=1); otherwise bit_cnt=0.
REQ-024 align shall not affect dout, dout_valid or overrun.
REQ-025 If align=1 coincides with what would be a completing bit, no completion occurs and align takes priority.
REQ-026 overrun_clr=1 shall clear overrun. If an overrun event occurs in the same cycle, set takes priority and overrun stays 1.
REQ-027 dout_ready while dout_valid=0 shall have no effect.

Reset
REQ-028 reset=1 at a rising edge shall force the shift register, dout, dout_valid, overrun and bit_cnt to 0, overriding all other inputs including a mid-word state or a pending output.
REQ-029 The first bit sampled after reset deasserts shall be bit 1 of a word.

Structure
REQ-030 The default WIDTH and the bit_cnt width function shall live in a shared serial package, together with the bit-order encoding used by the upstream PISO stage.
REQ-031 The shift register and bit counter shall form one sub-module, sipo_shift_core. The top level shall add the output slot, handshake and overrun logic.

Verification
REQ-032 Reset, then sin_valid=1 for 4 cycles with bits 1,0,1,1 (WIDTH=4, MSB_FIRST=1), dout_ready=1 -> one cycle after the 4th bit: dout=4'b1011, dout_valid=1.
REQ-033 Same bits with sin_valid toggling 1,0,1,0,... -> dout=4'b1011 after the 4th valid bit; bit_cnt holds its value during the gaps.
REQ-034 dout_ready=0, send 1011 then 0110 -> dout stays 4'b1011 and overrun=1; then dout_ready=1 -> dout_valid=0 the next cycle; then overrun_clr=1 -> overrun=0.
REQ-035 Word 1011 pending, dout_ready=1 raised exactly on the completing bit of 0110 -> dout=4'b0110, dout_valid stays 1, overrun=0.
REQ-036 Send 2 bits, pulse align with sin_valid=1 and sin=0, then send 1,1,1 -> dout=4'b0111; then repeat with MSB_FIRST=0 and bits 1,0,0,0 -> dout=4'b0001.
REQ-037 Assert reset after 3 bits with a word pending -> all outputs 0 on the next edge; 4 new bits then produce a correct word.
